// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one external pipelined fp_add_2 among NUM_REQ requesters
// Ports: clk/reset (async, active-high); enable gates new grants only.
//   req_valid/req_ready/req_a/req_b: per-requester operand handshake, operands packed [i*W +: W].
//   add_a/add_b: registered operands to the adder; add_sign/add_exponent/add_mantissa: adder result.
//   res_valid/res_id/res_data: tagged result, ADD_LATENCY+1 cycles after the handshake.
//   busy: any op in the issue register or the tag delay line.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ADD_LATENCY = 1,
  localparam int W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*W-1:0]      req_a,
  input  logic [NUM_REQ*W-1:0]      req_b,
  output logic [W-1:0]              add_a,
  output logic [W-1:0]              add_b,
  input  logic                      add_sign,
  input  logic [EXPONENT_WIDTH-1:0] add_exponent,
  input  logic [MANTISSA_WIDTH-1:0] add_mantissa,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [W-1:0]              res_data,
  output logic                      busy
);
  logic [ID_W-1:0] last_q, last_d, gidx;
  logic found;
  logic [W-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  // index 0 is the issue stage, index ADD_LATENCY lines up with the adder output
  logic [ADD_LATENCY:0] vld_q, vld_d;
  logic [ID_W-1:0] tag_q [ADD_LATENCY+1];
  logic [ID_W-1:0] tag_d [ADD_LATENCY+1];
  // search starts one past the last grant, so the last winner is checked last
  always_comb begin
    found = 1'b0;
    gidx = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (enable && !found && req_valid[ID_W'((int'(last_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        gidx = ID_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    last_d = gidx;
    add_a_d = found ? req_a[gidx*W +: W] : add_a_q;
    add_b_d = found ? req_b[gidx*W +: W] : add_b_q;
    vld_d = {vld_q[ADD_LATENCY-1:0], found};
    tag_d[0] = gidx;
    for (int k = 1; k <= ADD_LATENCY; k++) tag_d[k] = tag_q[k-1];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= ID_W'(NUM_REQ - 1);
      add_a_q <= '0;
      add_b_q <= '0;
      vld_q <= '0;
      for (int k = 0; k <= ADD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      last_q <= last_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      vld_q <= vld_d;
      for (int k = 0; k <= ADD_LATENCY; k++) tag_q[k] <= tag_d[k];
    end
  end
  assign req_ready = NUM_REQ'(found) << gidx;
  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign res_valid = vld_q[ADD_LATENCY];
  assign res_id = tag_q[ADD_LATENCY];
  assign res_data = {add_sign, add_exponent, add_mantissa};
  assign busy = |vld_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed checks of arbitration, tagging and result timing with a table-driven adder stub
module tb_fp_add_arbiter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [4*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0] add_a, add_b, res_data, sum_q;
  logic res_valid, busy;
  logic [1:0] res_id;
  int total = 0, bad = 0;

  fp_add_arbiter #(.NUM_REQ(4), .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ADD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b),
    .add_sign(sum_q[31]), .add_exponent(sum_q[30:23]), .add_mantissa(sum_q[22:0]),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // one-cycle fp_add_2 stand-in: knows only the sums used below
  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      {32'h40E80000, 32'h3EC00000}: return 32'h40F40000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h40400000, 32'h40400000}: return 32'h40C00000;
      {32'h40800000, 32'h40800000}: return 32'h41000000;
      {32'h42820000, 32'hC27C0000}: return 32'h40000000;
      {32'h40800000, 32'hC0800000}: return 32'h00000000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction
  always_ff @(posedge clk) sum_q <= fadd(add_a, add_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic no_result(input string tag);
    check({tag, "_rv"}, 64'(res_valid), 64'd0);
  endtask

  task automatic result(input string tag, input logic [1:0] id, input logic [W-1:0] d);
    check({tag, "_rv"}, 64'(res_valid), 64'd1);
    check({tag, "_id"}, 64'(res_id), 64'(id));
    check({tag, "_data"}, 64'(res_data), 64'(d));
  endtask

  logic [W-1:0] all_a [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [W-1:0] all_s [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

  initial begin
    #2;
    @(negedge clk);
    check("rst_rv", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    tick();
    reset = 1'b0;

    // 1: single op from requester 0
    tick();
    req_valid = 4'b0001;
    req_a[0 +: W] = 32'h40E80000;
    req_b[0 +: W] = 32'h3EC00000;
    @(negedge clk);
    check("t1_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    no_result("t1_c1");
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_add_a", 64'(add_a), 64'h40E80000);
    tick();
    @(negedge clk);
    result("t1", 2'd0, 32'h40F40000);
    tick();
    @(negedge clk);
    no_result("t1_c3");
    check("t1_idle", 64'(busy), 64'd0);

    // 2: all four continuously valid -> strict rotation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = all_a[i];
      req_b[i*W +: W] = all_a[i];
    end
    for (int c = 0; c < 10; c++) begin
      req_valid = c < 8 ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) check($sformatf("t2_ready%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 2) result($sformatf("t2_r%0d", c), 2'((c - 2) % 4), all_s[(c - 2) % 4]);
      tick();
    end
    @(negedge clk);
    no_result("t2_drain");

    // 3: sole valid requester gets back-to-back grants
    tick();
    req_a[2*W +: W] = 32'h42820000;
    req_b[2*W +: W] = 32'hC27C0000;
    for (int c = 0; c < 5; c++) begin
      req_valid = c < 3 ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (c < 3) check($sformatf("t3_ready%0d", c), 64'(req_ready), 64'b0100);
      if (c >= 2) result($sformatf("t3_r%0d", c), 2'd2, 32'h40000000);
      tick();
    end

    // 4: enable low blocks grants, then releases requester 1
    enable = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t4_ready%0d", c), 64'(req_ready), 64'd0);
      no_result($sformatf("t4_off%0d", c));
      tick();
    end
    enable = 1'b1;
    @(negedge clk);
    check("t4_ready_on", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    no_result("t4_c1");
    tick();
    @(negedge clk);
    result("t4", 2'd1, 32'h40800000);

    // 5: reset one cycle after a grant to requester 2
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    check("t5_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    no_result("t5_rst");
    check("t5_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    no_result("t5_after");
    check("t5_busy2", 64'(busy), 64'd0);
    tick();
    req_valid = 4'hF;
    @(negedge clk);
    check("t5_ptr", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    result("t5", 2'd0, 32'h40000000);

    // 6: exact cancellation through requester 3
    tick();
    req_a[3*W +: W] = 32'h40800000;
    req_b[3*W +: W] = 32'hC0800000;
    req_valid = 4'b1000;
    @(negedge clk);
    check("t6_ready", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    result("t6", 2'd3, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
